handshake_rr_ctrl_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream handshake channel between `NUM_INPUTS` control-token producers. Each cycle it picks one pending requester and forwards that requester's index as the output token. A downstream constant/mux stage uses the index to select which constant is emitted. It sits in front of shared `handshake_constant_*` and mux resources in the dataflow netlist, and sequences their use fairly.

---
 rtl/handshake_rr_ctrl_arbiter_pkg.sv | 16 +
 rtl/handshake_rr_ctrl_arbiter_if.sv | 35 +++
 rtl/handshake_rr_ctrl_arbiter_rr_priority_pick.sv | 52 +++++
 rtl/handshake_rr_ctrl_arbiter.sv | 124 ++++++++++++
 tb/tb_handshake_rr_ctrl_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_rr_ctrl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : handshake_pkg
// Purpose  : Shared constants and width helper for the handshake arbiters.
// Revision : 1.0
// ============================================================================
package handshake_pkg;

    localparam int MAX_ARB_INPUTS = 16;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_rr_ctrl_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : handshake_rr_ctrl_arbiter_if
// Purpose   : Requester bundle plus the shared downstream index channel.
// Revision  : 1.0
// ============================================================================
interface handshake_rr_ctrl_arbiter_if
    import handshake_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = clog2_min1(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0]  ins_valid;
    logic [NUM_INPUTS-1:0]  ins_ready;
    logic [INDEX_WIDTH-1:0] outs;
    logic                   outs_valid;
    logic                   outs_ready;

    modport master (
        input  ins_valid,
        input  outs_ready,
        output ins_ready,
        output outs,
        output outs_valid
    );

    modport slave (
        output ins_valid,
        output outs_ready,
        input  ins_ready,
        input  outs,
        input  outs_valid
    );
endinterface
`default_nettype wire

// File: rtl/handshake_rr_ctrl_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational round-robin pick: first set req bit at/after ptr.
// Revision : 1.0
// ============================================================================
module rr_priority_pick
    import handshake_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = clog2_min1(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0]  req,
    input  logic [INDEX_WIDTH-1:0] ptr,
    output logic [INDEX_WIDTH-1:0] grant_idx,
    output logic                   any
);
    logic [2*NUM_INPUTS-1:0] dbl;
    logic [NUM_INPUTS-1:0]   rot;
    logic [INDEX_WIDTH:0]    off;
    logic [INDEX_WIDTH:0]    sum;

    // Doubling the vector lets a plain index window act as a rotate by ptr.
    assign dbl = {req, req};
    assign any = |req;

    always_comb begin
        rot = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            rot[k] = dbl[int'(ptr) + k];
        end
    end

    always_comb begin
        off = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = (INDEX_WIDTH+1)'(k);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + off;
        if (sum >= (INDEX_WIDTH+1)'(NUM_INPUTS)) begin
            sum = sum - (INDEX_WIDTH+1)'(NUM_INPUTS);
        end
    end

    assign grant_idx = sum[INDEX_WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/handshake_rr_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : handshake_rr_ctrl_arbiter
// Purpose  : Fair round-robin share of one index channel among NUM_INPUTS
//            requesters. HANDSHAKE_RR_ARB_OUT_REG_EN adds a 1-entry output reg.
// Revision : 1.0
// ============================================================================
module handshake_rr_ctrl_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = clog2_min1(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    handshake_rr_ctrl_arbiter_if.master  bus
);
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] pick_idx;
    logic                   pick_any;
    logic [INDEX_WIDTH-1:0] winner;
    logic                   grant_fire;
    logic [NUM_INPUTS-1:0]  ready_vec;

    function automatic logic [INDEX_WIDTH-1:0] wrap_inc(input logic [INDEX_WIDTH-1:0] idx);
        if (int'(idx) >= NUM_INPUTS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    rr_priority_pick #(
        .NUM_INPUTS  (NUM_INPUTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .req       (bus.ins_valid),
        .ptr       (ptr_q),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            ready_vec[i] = grant_fire && (int'(winner) == i);
        end
    end
    assign bus.ins_ready = ready_vec;

`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
    logic                   lock_q, lock_d;
    logic [INDEX_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic                   out_valid;

    // A stalled grant is pinned so outs cannot change under a waiting consumer.
    assign winner         = lock_q ? lock_idx_q : pick_idx;
    assign out_valid      = lock_q | pick_any;
    assign grant_fire     = bus.outs_ready & out_valid;
    assign bus.outs       = winner;
    assign bus.outs_valid = out_valid;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (grant_fire) begin
            ptr_d  = wrap_inc(winner);
            lock_d = 1'b0;
        end else if (out_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic                   full_q, full_d;
    logic [INDEX_WIDTH-1:0] data_q, data_d;
    logic                   accept;

    // The register holds the token stable, so no lock is needed here.
    assign winner         = pick_idx;
    assign accept         = !full_q | bus.outs_ready;
    assign grant_fire     = accept & pick_any;
    assign bus.outs       = data_q;
    assign bus.outs_valid = full_q;

    always_comb begin
        ptr_d  = ptr_q;
        full_d = full_q;
        data_d = data_q;
        if (grant_fire) begin
            full_d = 1'b1;
            data_d = pick_idx;
            ptr_d  = wrap_inc(pick_idx);
        end else if (bus.outs_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            full_q <= full_d;
            data_q <= data_d;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_handshake_rr_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_rr_ctrl_arbiter
// Purpose  : Random + directed bench for a 4-input and a 3-input arbiter.
// Revision : 1.0
// ============================================================================
module tb_handshake_rr_ctrl_arbiter;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    // Reference state, per instance: [0] = 4 inputs, [1] = 3 inputs.
    int mptr  [2];
    int mheld [2];
    bit mfull [2];
    int mdata [2];

    int rdy0, rdy1;
    int obs_outs0, obs_rdy0;
    int pend0, pend1;

    handshake_rr_ctrl_arbiter_if #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) bus0 ();
    handshake_rr_ctrl_arbiter_if #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) bus1 ();

    handshake_rr_ctrl_arbiter #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    handshake_rr_ctrl_arbiter #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rr_first(input int n, input int p, input int v);
        for (int i = 0; i < n; i++) begin
            if (((v >> ((p + i) % n)) & 1) != 0) return (p + i) % n;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            mptr[k]  = 0;
            mheld[k] = -1;
            mfull[k] = 1'b0;
            mdata[k] = 0;
        end
    endtask

    task automatic check_inst(input int k, input int v, input bit r, input int o_val,
                              input int o_idx, input int o_rdy, input bit upd,
                              output int rdy_exp);
        int n;
        int pick;
        int idx_e;
        bit val_e;
        n    = (k == 0) ? 4 : 3;
        pick = rr_first(n, mptr[k], v);
`ifdef HANDSHAKE_RR_ARB_OUT_REG_EN
        val_e   = mfull[k];
        idx_e   = mdata[k];
        rdy_exp = ((!mfull[k] || r) && pick >= 0) ? (1 << pick) : 0;
`else
        idx_e   = (mheld[k] >= 0) ? mheld[k] : pick;
        val_e   = (idx_e >= 0);
        rdy_exp = (val_e && r) ? (1 << idx_e) : 0;
`endif
        check($sformatf("i%0d_outs_valid", k), o_val, int'(val_e));
        if (val_e) check($sformatf("i%0d_outs", k), o_idx, idx_e);
        check($sformatf("i%0d_ins_ready", k), o_rdy, rdy_exp);
        if (upd) begin
`ifdef HANDSHAKE_RR_ARB_OUT_REG_EN
            if (rdy_exp != 0) begin
                mfull[k] = 1'b1;
                mdata[k] = pick;
                mptr[k]  = (pick + 1) % n;
            end else if (r) begin
                mfull[k] = 1'b0;
            end
`else
            if (val_e && r) begin
                mptr[k]  = (idx_e + 1) % n;
                mheld[k] = -1;
            end else if (val_e) begin
                mheld[k] = idx_e;
            end
`endif
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input int v0, input bit r0, input int v1, input bit r1);
        bus0.ins_valid  = 4'(v0);
        bus0.outs_ready = r0;
        bus1.ins_valid  = 3'(v1);
        bus1.outs_ready = r1;
        @(negedge clk);
        obs_outs0 = int'(bus0.outs);
        obs_rdy0  = int'(bus0.ins_ready);
        check_inst(0, v0, r0, int'(bus0.outs_valid), int'(bus0.outs), int'(bus0.ins_ready), 1'b1, rdy0);
        check_inst(1, v1, r1, int'(bus1.outs_valid), int'(bus1.outs), int'(bus1.ins_ready), 1'b1, rdy1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp [6];
        int stall_exp [5];
        int dummy;
        n_checks = 0;
        n_errors = 0;
        rr_exp    = '{1, 2, 3, 0, 1, 2};
        stall_exp = '{2, 2, 2, 2, 1};

        rst             = 1'b0;
        bus0.ins_valid  = 4'b0001;
        bus0.outs_ready = 1'b1;
        bus1.ins_valid  = 3'b000;
        bus1.outs_ready = 1'b1;
        reset_model();

        // Held in reset across an edge: state must not move.
        @(posedge clk);
        @(negedge clk);
        check_inst(0, 1, 1'b1, int'(bus0.outs_valid), int'(bus0.outs), int'(bus0.ins_ready), 1'b0, dummy);
        check_inst(1, 0, 1'b1, int'(bus1.outs_valid), int'(bus1.outs), int'(bus1.ins_ready), 1'b0, dummy);
        @(posedge clk);
        #1;
        rst = 1'b1;

        cycle(4'b0001, 1'b1, 0, 1'b1);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
        check("first_outs", obs_outs0, 0);
        check("first_ready", obs_rdy0, 1);
`endif

        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b1, 0, 1'b1);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
            check("rr_order", obs_outs0, rr_exp[i]);
            check("rr_onehot", obs_rdy0, 1 << rr_exp[i]);
`endif
        end

        // Stall on input 2; input 1 arrives mid-stall and must wait.
        for (int i = 0; i < 5; i++) begin
            cycle((i == 0) ? 4'b0100 : (i == 4) ? 4'b0010 : 4'b0110, i >= 3, 0, 1'b1);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
            check("stall_outs", obs_outs0, stall_exp[i]);
`endif
        end

        cycle(4'b0100, 1'b1, 0, 1'b1);
        cycle(4'b1001, 1'b1, 0, 1'b1);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
        check("wrap_outs3", obs_outs0, 3);
`endif
        cycle(4'b0001, 1'b1, 0, 1'b1);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
        check("wrap_outs0", obs_outs0, 0);
`endif

        // Lock onto input 2, then reset asynchronously mid-cycle.
        cycle(4'b0100, 1'b0, 0, 1'b1);
        bus0.ins_valid  = 4'b0110;
        bus0.outs_ready = 1'b0;
        #2;
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
        check("locked_outs", int'(bus0.outs), 2);
`endif
        rst = 1'b0;
        #1;
        reset_model();
        check_inst(0, 6, 1'b0, int'(bus0.outs_valid), int'(bus0.outs), int'(bus0.ins_ready), 1'b0, dummy);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
        check("rst_async_outs", int'(bus0.outs), 1);
`else
        check("rst_async_valid", int'(bus0.outs_valid), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(4'b0110, 1'b1, 0, 1'b1);
`ifndef HANDSHAKE_RR_ARB_OUT_REG_EN
        check("post_rst_outs", obs_outs0, 1);
`endif
        cycle(0, 1'b1, 0, 1'b1);

        // Random traffic on both instances; producers keep valid until accepted.
        pend0 = 0;
        pend1 = 0;
        rdy0  = 0;
        rdy1  = 0;
        for (int c = 0; c < 400; c++) begin
            pend0 = (pend0 & ~rdy0) | int'($urandom & $urandom & 32'hF);
            pend1 = (pend1 & ~rdy1) | int'($urandom & $urandom & 32'h7);
            cycle(pend0, $urandom_range(0, 9) < 7, pend1, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
